// File: rtl/reset_button_conditioner_pkg.sv
// Shared definitions for the reset/button front end: FSM state encoding,
// saturation limit for the soft-reset counter and a counter-width helper.
package reset_button_conditioner_pkg;

    // Debounce/press tracking states; 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // reset_count saturates here instead of wrapping.
    localparam logic [7:0] RESET_COUNT_MAX = 8'hFF;

    // Bits needed to hold the values 0..limit inclusive.
    function automatic int count_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/reset_button_conditioner_sync_chain.sv
// Multi-flop synchroniser with asynchronous active-low clear. Used both for
// the reset-release path (d tied high) and for the raw pushbutton.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_reg;

    // Shift the input through STAGES flops; the whole chain clears on reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/reset_button_conditioner.sv
// Board-level reset conditioner: synchronises and stretches the external
// reset, debounces the pushbutton and turns a long hold into a soft reset.
// DEBOUNCE_CYCLES is expected to be at least 2 and STRETCH_CYCLES at least 1.
module reset_button_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 24000000,
    parameter int STRETCH_CYCLES  = 1024,
    parameter bit LONG_RESET      = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_RAW,
    output logic       rst_out_n,
    output logic       btn_level,
    output logic       btn_press,
    output logic       long_press,
    output logic [7:0] reset_count
);

    import reset_button_conditioner_pkg::*;

    localparam int DW = count_width(DEBOUNCE_CYCLES);
    localparam int LW = count_width(LONG_CYCLES);
    localparam int SW = count_width(STRETCH_CYCLES);

    localparam logic [DW-1:0] DEB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX     = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_LAST    = LW'(LONG_CYCLES - 1);
    localparam logic [SW-1:0] STRETCH_MAX  = SW'(STRETCH_CYCLES);
    localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH_CYCLES - 1);

    logic            rel_s;
    logic            btn_s;
    logic            soft_fire;
    logic [SW-1:0]   stretch_cnt_reg;
    logic [DW-1:0]   deb_cnt_reg;
    logic [LW-1:0]   long_cnt_reg;
    btn_state_t      state_reg;

    sync_chain #(.STAGES(SYNC_STAGES)) u_rel_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (1'b1),
        .q     (rel_s)
    );

    sync_chain #(.STAGES(SYNC_STAGES)) u_btn_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (BTN_RAW),
        .q     (btn_s)
    );

    // The long_press pulse is already synchronous, so it reloads the stretch directly.
    assign soft_fire = LONG_RESET && long_press;

    // Reset output: held low until the synchronised release has been stable
    // for STRETCH_CYCLES edges; a soft reset restarts the stretch.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stretch_cnt_reg <= '0;
            rst_out_n       <= 1'b0;
            reset_count     <= '0;
        end else if (soft_fire) begin
            stretch_cnt_reg <= '0;
            rst_out_n       <= 1'b0;
            if (reset_count != RESET_COUNT_MAX) begin
                reset_count <= reset_count + 8'd1;
            end
        end else if (rel_s && stretch_cnt_reg != STRETCH_MAX) begin
            stretch_cnt_reg <= stretch_cnt_reg + SW'(1);
            if (stretch_cnt_reg == STRETCH_LAST) begin
                rst_out_n <= 1'b1;
            end
        end
    end

    // Debounce FSM plus long-press timer; the long count is evaluated before
    // any state change so a release on the firing edge still lets it fire.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg    <= IDLE;
            deb_cnt_reg  <= '0;
            long_cnt_reg <= '0;
            btn_level    <= 1'b0;
            btn_press    <= 1'b0;
            long_press   <= 1'b0;
        end else begin
            btn_press  <= 1'b0;
            long_press <= 1'b0;

            // Long timer runs while the debounced level is high, saturating so it fires once.
            if ((state_reg == PRESSED || state_reg == RELEASE_WAIT) && long_cnt_reg != LONG_MAX) begin
                long_cnt_reg <= long_cnt_reg + LW'(1);
                if (long_cnt_reg == LONG_LAST) begin
                    long_press <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (btn_s) begin
                        state_reg   <= PRESS_WAIT;
                        deb_cnt_reg <= DW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state_reg   <= IDLE;
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg == DEB_LAST) begin
                        state_reg    <= PRESSED;
                        deb_cnt_reg  <= '0;
                        long_cnt_reg <= '0;
                        btn_level    <= 1'b1;
                        btn_press    <= 1'b1;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + DW'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state_reg   <= RELEASE_WAIT;
                        deb_cnt_reg <= DW'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state_reg   <= PRESSED;
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg == DEB_LAST) begin
                        state_reg    <= IDLE;
                        deb_cnt_reg  <= '0;
                        long_cnt_reg <= '0;
                        btn_level    <= 1'b0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + DW'(1);
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    deb_cnt_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_button_conditioner.sv
// Self-checking bench: two instances (LONG_RESET=1 and 0) share stimulus and
// are compared every cycle against an edge-indexed reference model.
module tb_reset_button_conditioner;

    localparam int SYNC    = 2;
    localparam int DEB     = 4;
    localparam int LONG    = 20;
    localparam int STRETCH = 8;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       BTN_RAW = 1'b0;
    logic       rst1, lvl1, prs1, lp1;
    logic       rst0, lvl0, prs0, lp0;
    logic [7:0] cnt1, cnt0;

    int checks = 0;
    int failures = 0;

    // Reference model state, indexed by rising-edge number.
    int         edge_n = 0;
    int         k0 = 0;          // last edge sampled with RESET low
    int         last_flip = 0;   // edge of last accepted level change
    int         rise_edge = -1000;
    int         soft_rel = 0;    // earliest edge the soft stretch allows release
    bit         raw_hist [64];
    bit         samp_hist [64];
    bit         m_level = 0, m_press = 0, m_long = 0, m_rst1 = 0, m_rst0 = 0;
    logic [7:0] m_count1 = 8'd0;

    reset_button_conditioner #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG),
        .STRETCH_CYCLES(STRETCH), .LONG_RESET(1'b1)
    ) dut1 (
        .CLK(CLK), .RESET(RESET), .BTN_RAW(BTN_RAW), .rst_out_n(rst1),
        .btn_level(lvl1), .btn_press(prs1), .long_press(lp1), .reset_count(cnt1)
    );

    reset_button_conditioner #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG),
        .STRETCH_CYCLES(STRETCH), .LONG_RESET(1'b0)
    ) dut0 (
        .CLK(CLK), .RESET(RESET), .BTN_RAW(BTN_RAW), .rst_out_n(rst0),
        .btn_level(lvl0), .btn_press(prs0), .long_press(lp0), .reset_count(cnt0)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [23:0] dut_vec();
        return {rst1, rst0, lvl1, lvl0, prs1, prs0, lp1, lp0, cnt1, cnt0};
    endfunction

    function automatic logic [23:0] model_vec();
        return {m_rst1, m_rst0, m_level, m_level, m_press, m_press, m_long, m_long, m_count1, 8'd0};
    endfunction

    // Advance one clock; update the model from the inputs seen at the edge.
    task automatic tick();
        bit all_diff;
        bit new_long;
        @(posedge CLK);
        edge_n++;
        if (!RESET) begin
            k0 = edge_n; last_flip = edge_n; rise_edge = -1000; soft_rel = 0;
            m_level = 0; m_press = 0; m_long = 0; m_rst1 = 0; m_rst0 = 0; m_count1 = 8'd0;
            raw_hist[edge_n % 64] = 1'b0;
        end else begin
            raw_hist[edge_n % 64] = BTN_RAW;
            // button value seen by the debouncer: raw from SYNC edges back
            samp_hist[edge_n % 64] = (edge_n - SYNC > k0) ? raw_hist[(edge_n - SYNC) % 64] : 1'b0;
            // a long_press visible last cycle triggers a soft reset now
            if (m_long) begin
                soft_rel = edge_n + STRETCH;
                if (m_count1 != 8'd255) m_count1 = m_count1 + 8'd1;
            end
            // long press fires exactly LONG edges after the press was accepted
            new_long = m_level && (edge_n - rise_edge == LONG);
            // a change is accepted once DEB consecutive samples disagree with the level
            all_diff = 1'b0;
            if (edge_n - last_flip >= DEB) begin
                all_diff = 1'b1;
                for (int i = 0; i < DEB; i++)
                    if (samp_hist[(edge_n - i) % 64] == m_level) all_diff = 1'b0;
            end
            m_press = all_diff && !m_level;
            if (all_diff) begin
                m_level = !m_level;
                last_flip = edge_n;
                if (m_level) rise_edge = edge_n;
            end
            m_long = new_long;
            m_rst0 = (edge_n >= k0 + SYNC + STRETCH);
            m_rst1 = m_rst0 && (edge_n >= soft_rel);
        end
        #1;
    endtask

    task automatic test_reset();
        int rise_at;
        BTN_RAW = 1'b0;
        for (int ph = 0; ph < 4; ph++) begin
            RESET = 1'b0;
            if (m_rst0) begin
                #1;
                checks++;
                if (rst1 !== 1'b0 || rst0 !== 1'b0) begin
                    failures++;
                    $display("FAIL async_assert: got rst=%b%b required=00", rst1, rst0);
                end
            end
            repeat ((ph == 1) ? 1 : 3) tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL reset_state: got=%h required=%h", dut_vec(), model_vec());
            end
            RESET = 1'b1;
            rise_at = 0;
            for (int i = 1; i <= ((ph == 1) ? 5 : 12); i++) begin
                tick();
                checks++;
                if (dut_vec() !== model_vec()) begin
                    failures++;
                    $display("FAIL release_seq ph=%0d i=%0d: got=%h required=%h", ph, i, dut_vec(), model_vec());
                end
                if (rst1 && rise_at == 0) rise_at = i;
            end
            if (ph != 1) begin
                checks++;
                if (rise_at != SYNC + STRETCH) begin
                    failures++;
                    $display("FAIL release_edge ph=%0d: got=%0d required=%0d", ph, rise_at, SYNC + STRETCH);
                end
            end
        end
    endtask

    task automatic test_glitch();
        bit seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            BTN_RAW = (i < 3);
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL glitch i=%0d: got=%h required=%h", i, dut_vec(), model_vec());
            end
            if (lvl1 || prs1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL glitch_ignored: got level/press seen=%b required=0", seen);
        end
    endtask

    task automatic test_clean_press();
        int press_at = 0, n_press = 0, fall_at = 0;
        for (int i = 1; i <= 20; i++) begin
            BTN_RAW = (i <= 10);
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL clean_press i=%0d: got=%h required=%h", i, dut_vec(), model_vec());
            end
            if (prs1) begin
                n_press++;
                if (press_at == 0) press_at = i;
            end
            if (i > 10 && !lvl1 && fall_at == 0) fall_at = i - 10;
        end
        checks++;
        if (press_at != SYNC + DEB || n_press != 1) begin
            failures++;
            $display("FAIL press_latency: got at=%0d n=%0d required at=%0d n=1", press_at, n_press, SYNC + DEB);
        end
        checks++;
        if (fall_at != SYNC + DEB) begin
            failures++;
            $display("FAIL release_latency: got=%0d required=%0d", fall_at, SYNC + DEB);
        end
    endtask

    task automatic test_long_press();
        int press_at = 0, long_at = 0, n_long = 0, low1 = 0, low0 = 0;
        bit dropped = 1'b0;
        for (int i = 1; i <= 52; i++) begin
            BTN_RAW = (i <= 40);
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL long_press i=%0d: got=%h required=%h", i, dut_vec(), model_vec());
            end
            if (prs1 && press_at == 0) press_at = i;
            if (lp1) begin
                n_long++;
                if (long_at == 0) long_at = i;
            end
            if (!rst1) low1++;
            if (!rst0) low0++;
            if (press_at != 0 && i <= 40 && !lvl1) dropped = 1'b1;
        end
        checks++;
        if (n_long != 1 || long_at - press_at != LONG) begin
            failures++;
            $display("FAIL long_timing: got n=%0d dist=%0d required n=1 dist=%0d", n_long, long_at - press_at, LONG);
        end
        checks++;
        if (low1 != STRETCH || low0 != 0) begin
            failures++;
            $display("FAIL soft_reset_width: got low1=%0d low0=%0d required %0d/0", low1, low0, STRETCH);
        end
        checks++;
        if (dropped !== 1'b0 || cnt1 !== 8'd1) begin
            failures++;
            $display("FAIL hold_state: got dropped=%b count=%0d required 0/1", dropped, cnt1);
        end
    endtask

    task automatic test_bounce();
        bit sched [1:52];
        bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int pos = 9, len;
        int press_at = 0, long_at = 0, n_long = 0;
        bit dropped = 1'b0;
        for (int i = 1; i <= 52; i++) sched[i] = (i <= 40);
        for (int p = 0; p < 5; p++) begin
            len = $urandom_range(1, DEB - 1);
            for (int j = 0; j < len; j++) sched[pos + j] = pat[p];
            pos += len;
        end
        for (int i = 1; i <= 52; i++) begin
            BTN_RAW = sched[i];
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL bounce i=%0d: got=%h required=%h", i, dut_vec(), model_vec());
            end
            if (prs1 && press_at == 0) press_at = i;
            if (lp1) begin
                n_long++;
                if (long_at == 0) long_at = i;
            end
            if (press_at != 0 && i <= 40 && !lvl1) dropped = 1'b1;
        end
        checks++;
        if (dropped !== 1'b0 || n_long != 1 || long_at - press_at != LONG) begin
            failures++;
            $display("FAIL bounce_hold: got dropped=%b n=%0d dist=%0d required 0/1/%0d",
                     dropped, n_long, long_at - press_at, LONG);
        end
    endtask

    task automatic test_saturate();
        int hold, gap, n_long0 = 0, low0 = 0;
        for (int n = 0; n < 256; n++) begin
            hold = (n == 0) ? LONG : $urandom_range(LONG, LONG + 10);
            gap  = $urandom_range(SYNC + DEB + 1, SYNC + DEB + 6);
            for (int i = 0; i < hold + gap; i++) begin
                BTN_RAW = (i < hold);
                tick();
                checks++;
                if (dut_vec() !== model_vec()) begin
                    failures++;
                    $display("FAIL saturate n=%0d i=%0d: got=%h required=%h", n, i, dut_vec(), model_vec());
                end
                if (lp0) n_long0++;
                if (!rst0) low0++;
            end
        end
        checks++;
        if (cnt1 !== 8'd255 || cnt0 !== 8'd0) begin
            failures++;
            $display("FAIL count_saturate: got %0d/%0d required 255/0", cnt1, cnt0);
        end
        checks++;
        if (n_long0 != 256 || low0 != 0) begin
            failures++;
            $display("FAIL no_soft_reset: got pulses=%0d low=%0d required 256/0", n_long0, low0);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_clean_press();
        test_long_press();
        test_bounce();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
